blit_pixel_writer: RTL and testbench

- Final memory stage of the blitter pipeline; consumes the per-pixel source/destination addresses produced by the address-generation stage (p3 signals).
- Per pixel: optionally fetches the source byte, resolves colour (copy, solid fill, 1bpp text expansion), applies transparency, then issues the destination byte write.
- Back-pressures the pipeline through `stall` while a pixel is in flight. Drives a single-outstanding req/ack byte memory port.

---
 rtl/blit_pixel_writer.sv | 252 +++++++++++++++++++++++++
 tb/tb_blit_pixel_writer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_pixel_writer.sv
// blit_pixel_writer: final memory stage of the blitter pipeline.
// Per pixel it optionally fetches the source byte, resolves the colour (copy,
// solid fill or 1bpp text expansion), applies transparency and issues the
// destination byte write over a single-outstanding req/ack byte port.
// Optional feature: define BLIT_SRC_CACHE_EN for a one-entry source byte cache.
module blit_pixel_writer #(
    parameter int unsigned ADDR_W = 26
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       p3_src_addr,
    input  logic [ADDR_W-1:0] p3_dest_addr,
    input  logic [2:0]        p3_src_bit,
    input  logic              p3_write_en,
    input  logic              p3_src_read,
    input  logic              p3_textmode,
    input  logic [7:0]        fg_color,
    input  logic [7:0]        bg_color,
    input  logic [7:0]        trans_color,
    input  logic              trans_en,
    output logic              stall,
    output logic              idle,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;

    // latched pixel op fields
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [BIT_W-1:0]    src_bit_q, src_bit_d;
    logic                textmode_q, textmode_d;
    logic [DATA_W-1:0]   fg_q, fg_d;
    logic [DATA_W-1:0]   bg_q, bg_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic                key_en_q, key_en_d;

    // next values of the registered outputs
    logic                stall_d;
    logic                req_d;
    logic                write_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    // {write_needed, colour}
    logic [DATA_W:0]     res_c;

`ifdef BLIT_SRC_CACHE_EN
    logic                cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0]   cache_tag_q, cache_tag_d;
    logic [DATA_W-1:0]   cache_data_q, cache_data_d;
    logic                cache_hit_c;

    // source hit against the single cached byte
    assign cache_hit_c = cache_valid_q && (cache_tag_q == p3_src_addr[ADDR_W-1:0]);
`endif

    // upper source address bits are outside the memory space
    if (ADDR_W < 32) begin : g_src_hi
        logic unused_src_hi;
        assign unused_src_hi = ^p3_src_addr[31:ADDR_W];
    end

    // colour resolution: text expansion (MSB = leftmost pixel) or copy with key
    function automatic logic [DATA_W:0] resolve_pixel(
        input logic [DATA_W-1:0] data,
        input logic              textmode,
        input logic [BIT_W-1:0]  src_bit,
        input logic [DATA_W-1:0] fg,
        input logic [DATA_W-1:0] bg,
        input logic [DATA_W-1:0] key,
        input logic              key_en
    );
        logic [BIT_W-1:0] idx;
        logic             pix;
        idx = BIT_W'(3'd7 - src_bit);
        pix = data[idx];
        if (textmode) begin
            if (pix) begin
                resolve_pixel = {1'b1, fg};
            end else begin
                resolve_pixel = {!key_en, bg};
            end
        end else begin
            resolve_pixel = {!(key_en && (data == key)), data};
        end
    endfunction

    assign idle = (state_q == IDLE) && !p3_write_en;

    // state, latched op fields, memory port and cache registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            dest_q        <= '0;
            src_bit_q     <= '0;
            textmode_q    <= 1'b0;
            fg_q          <= '0;
            bg_q          <= '0;
            key_q         <= '0;
            key_en_q      <= 1'b0;
            stall         <= 1'b0;
            mem_req       <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
`ifdef BLIT_SRC_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            dest_q        <= dest_d;
            src_bit_q     <= src_bit_d;
            textmode_q    <= textmode_d;
            fg_q          <= fg_d;
            bg_q          <= bg_d;
            key_q         <= key_d;
            key_en_q      <= key_en_d;
            stall         <= stall_d;
            mem_req       <= req_d;
            mem_write     <= write_d;
            mem_addr      <= addr_d;
            mem_wdata     <= wdata_d;
`ifdef BLIT_SRC_CACHE_EN
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
`endif
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        dest_d        = dest_q;
        src_bit_d     = src_bit_q;
        textmode_d    = textmode_q;
        fg_d          = fg_q;
        bg_d          = bg_q;
        key_d         = key_q;
        key_en_d      = key_en_q;
        req_d         = mem_req;
        write_d       = mem_write;
        addr_d        = mem_addr;
        wdata_d       = mem_wdata;
        res_c         = '0;
`ifdef BLIT_SRC_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (p3_write_en) begin
                    dest_d     = p3_dest_addr;
                    src_bit_d  = p3_src_bit;
                    textmode_d = p3_textmode;
                    fg_d       = fg_color;
                    bg_d       = bg_color;
                    key_d      = trans_color;
                    key_en_d   = trans_en;
                    if (p3_src_read) begin
                        state_d = READ;
                        req_d   = 1'b1;
                        write_d = 1'b0;
                        addr_d  = p3_src_addr[ADDR_W-1:0];
`ifdef BLIT_SRC_CACHE_EN
                        if (cache_hit_c) begin
                            res_c = resolve_pixel(cache_data_q, p3_textmode, p3_src_bit,
                                                  fg_color, bg_color, trans_color, trans_en);
                            if (res_c[DATA_W]) begin
                                state_d = WRITE;
                                write_d = 1'b1;
                                addr_d  = p3_dest_addr;
                                wdata_d = res_c[DATA_W-1:0];
                            end else begin
                                state_d = IDLE;
                                req_d   = 1'b0;
                                write_d = mem_write;
                                addr_d  = mem_addr;
                            end
                        end
`endif
                    end else begin
                        state_d = WRITE;
                        req_d   = 1'b1;
                        write_d = 1'b1;
                        addr_d  = p3_dest_addr;
                        wdata_d = fg_color;
                    end
                end
            end

            READ: begin
                if (mem_ack) begin
                    res_c = resolve_pixel(mem_rdata, textmode_q, src_bit_q,
                                          fg_q, bg_q, key_q, key_en_q);
`ifdef BLIT_SRC_CACHE_EN
                    cache_valid_d = 1'b1;
                    cache_tag_d   = mem_addr;
                    cache_data_d  = mem_rdata;
`endif
                    if (res_c[DATA_W]) begin
                        state_d = WRITE;
                        write_d = 1'b1;
                        addr_d  = dest_q;
                        wdata_d = res_c[DATA_W-1:0];
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end

            WRITE: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
`ifdef BLIT_SRC_CACHE_EN
                    if (cache_valid_q && (mem_addr == cache_tag_q)) begin
                        cache_data_d = mem_wdata;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        stall_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_blit_pixel_writer.sv
// Self-checking bench for blit_pixel_writer: directed scenarios plus randomized
// pixels checked against a transaction-level reference model and memory model.
module tb_blit_pixel_writer;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned TXN_W  = ADDR_W + 9;

`ifdef BLIT_SRC_CACHE_EN
    localparam bit CACHE_EN    = 1'b1;
    localparam int CACHE_READS = 1;
`else
    localparam bit CACHE_EN    = 1'b0;
    localparam int CACHE_READS = 8;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       p3_src_addr = '0;
    logic [ADDR_W-1:0] p3_dest_addr = '0;
    logic [2:0]        p3_src_bit = '0;
    logic              p3_write_en = 1'b0;
    logic              p3_src_read = 1'b0;
    logic              p3_textmode = 1'b0;
    logic [7:0]        fg_color = '0;
    logic [7:0]        bg_color = '0;
    logic [7:0]        trans_color = '0;
    logic              trans_en = 1'b0;
    logic              stall;
    logic              idle;
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack = 1'b0;
    logic [7:0]        mem_rdata = '0;

    blit_pixel_writer #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .p3_src_addr(p3_src_addr), .p3_dest_addr(p3_dest_addr),
        .p3_src_bit(p3_src_bit), .p3_write_en(p3_write_en),
        .p3_src_read(p3_src_read), .p3_textmode(p3_textmode),
        .fg_color(fg_color), .bg_color(bg_color),
        .trans_color(trans_color), .trans_en(trans_en),
        .stall(stall), .idle(idle),
        .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // memory contents: reference side and DUT side, same initial pattern
    logic [7:0] ref_mem [int unsigned];
    logic [7:0] dut_mem [int unsigned];

    logic [TXN_W-1:0] obs_q [$];
    logic [TXN_W-1:0] exp_q [$];

    int ack_delay = 0;
    int wait_cnt  = 0;
    int stab_err  = 0;
    int idle_err  = 0;
    int drop_err  = 0;
    int tmo_cnt   = 0;
    int obs_stall = 0;
    int exp_stall = 0;

    bit                m_valid = 1'b0;
    logic [ADDR_W-1:0] m_tag   = '0;

    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [7:0]        cap_wdata;

    function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
        int unsigned x;
        x = 32'(a);
        return 8'((x * 37) ^ (x >> 7));
    endfunction

    function automatic logic [7:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(32'(a))) return ref_mem[32'(a)];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] dut_rd(input logic [ADDR_W-1:0] a);
        if (dut_mem.exists(32'(a))) return dut_mem[32'(a)];
        return init_byte(a);
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] v);
        ref_mem[32'(a)] = v;
        dut_mem[32'(a)] = v;
    endtask

    // memory responder: acks each request after ack_delay waiting cycles
    initial begin
        forever begin
            @(negedge clock);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (reset_n && mem_req) begin
                if (wait_cnt == 0) begin
                    cap_write = mem_write;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                end else if (mem_write !== cap_write || mem_addr !== cap_addr ||
                             (mem_write && mem_wdata !== cap_wdata)) begin
                    stab_err++;
                end
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_write) begin
                        dut_mem[32'(mem_addr)] = mem_wdata;
                        obs_q.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = dut_rd(mem_addr);
                        obs_q.push_back({1'b0, mem_addr, 8'h00});
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // reference: expected transactions of one pixel from the operation rules
    function automatic int model_pixel(input logic [31:0] src, input logic [ADDR_W-1:0] dest,
                                       input logic [2:0] sbit, input logic rd, input logic txt,
                                       input logic [7:0] fg, input logic [7:0] bg,
                                       input logic [7:0] tc, input logic te);
        logic [ADDR_W-1:0] a;
        logic [7:0]        data;
        logic [7:0]        col;
        logic [2:0]        idx;
        bit                skip;
        int                n;
        n    = 0;
        skip = 1'b0;
        col  = fg;
        if (rd) begin
            a    = src[ADDR_W-1:0];
            data = ref_rd(a);
            if (!(CACHE_EN && m_valid && m_tag == a)) begin
                exp_q.push_back({1'b0, a, 8'h00});
                n++;
            end
            m_valid = 1'b1;
            m_tag   = a;
            if (txt) begin
                idx = 3'(7 - int'(sbit));
                if (data[idx]) col = fg;
                else if (te) skip = 1'b1;
                else col = bg;
            end else begin
                col  = data;
                skip = te && (data == tc);
            end
        end
        if (!skip) begin
            exp_q.push_back({1'b1, dest, col});
            ref_mem[32'(dest)] = col;
            n++;
        end
        return n;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        obs_stall = 0;
        exp_stall = 0;
        idle_err  = 0;
        drop_err  = 0;
        tmo_cnt   = 0;
        stab_err  = 0;
    endtask

    // present one pixel, then wait for the stage to drain; records observations
    task automatic run_pixel(input logic [31:0] src, input logic [ADDR_W-1:0] dest,
                             input logic [2:0] sbit, input logic rd, input logic txt,
                             input logic [7:0] fg, input logic [7:0] bg,
                             input logic [7:0] tc, input logic te, input int d);
        int n;
        int cyc;
        n = model_pixel(src, dest, sbit, rd, txt, fg, bg, tc, te);
        exp_stall += n * (d + 1);
        ack_delay = d;
        p3_src_addr  = src;
        p3_dest_addr = dest;
        p3_src_bit   = sbit;
        p3_src_read  = rd;
        p3_textmode  = txt;
        fg_color     = fg;
        bg_color     = bg;
        trans_color  = tc;
        trans_en     = te;
        p3_write_en  = 1'b1;
        #1;
        if (idle !== 1'b0) idle_err++;
        @(negedge clock);
        p3_write_en  = 1'b0;
        p3_src_addr  = $urandom;
        p3_dest_addr = ADDR_W'($urandom);
        p3_src_bit   = 3'($urandom);
        p3_src_read  = 1'($urandom);
        p3_textmode  = 1'($urandom);
        fg_color     = 8'($urandom);
        bg_color     = 8'($urandom);
        trans_color  = 8'($urandom);
        trans_en     = 1'($urandom);
        cyc = 0;
        while (stall === 1'b1 && cyc < 200) begin
            obs_stall++;
            if (mem_req !== 1'b1) drop_err++;
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 200) tmo_cnt++;
        #1;
        if (idle !== 1'b1) idle_err++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({stall, idle, mem_req, mem_write} !== 4'b0100) $display("FAIL reset_ctl: got %b want 0100", {stall, idle, mem_req, mem_write});
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0) $display("FAIL reset_addr: got %h want 0", mem_addr);
        else n_pass++;
        n_checks++;
        if (mem_wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", mem_wdata);
        else n_pass++;
    endtask

    task automatic test_fill();
        clear_obs();
        run_pixel(32'h0, 26'h000100, 3'd0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0, 2);
        n_checks++;
        if (obs_q.size() != 1) $display("FAIL fill_count: got %0d want 1", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL fill_txn[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_stall != 3) $display("FAIL fill_stall: got %0d want 3", obs_stall);
        else n_pass++;
        n_checks++;
        if (idle_err + drop_err + tmo_cnt + stab_err != 0) $display("FAIL fill_proto: got %0d/%0d/%0d/%0d want 0", idle_err, drop_err, tmo_cnt, stab_err);
        else n_pass++;
    endtask

    task automatic test_copy();
        clear_obs();
        preload(26'h002000, 8'h55);
        run_pixel(32'h2000, 26'h000040, 3'd0, 1'b1, 1'b0, 8'h11, 8'h22, 8'h55, 1'b0, 1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL copy_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL copy_txn[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_stall != exp_stall || drop_err != 0) $display("FAIL copy_stall: got %0d drops %0d want %0d drops 0", obs_stall, drop_err, exp_stall);
        else n_pass++;
        n_checks++;
        if (idle_err + tmo_cnt + stab_err != 0) $display("FAIL copy_proto: got %0d/%0d/%0d want 0", idle_err, tmo_cnt, stab_err);
        else n_pass++;
    endtask

    task automatic test_transparency();
        clear_obs();
        preload(26'h002100, 8'h55);
        preload(26'h002101, 8'h56);
        run_pixel(32'h2100, 26'h000050, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h55, 1'b1, 0);
        run_pixel(32'h2101, 26'h000051, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h55, 1'b1, 2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL trans_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL trans_txn[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_stall != exp_stall || idle_err + drop_err + tmo_cnt + stab_err != 0) $display("FAIL trans_proto: got stall %0d err %0d want stall %0d err 0", obs_stall, idle_err + drop_err + tmo_cnt + stab_err, exp_stall);
        else n_pass++;
    endtask

    task automatic test_text();
        clear_obs();
        preload(26'h001000, 8'h80);
        run_pixel(32'h1000, 26'h000060, 3'd0, 1'b1, 1'b1, 8'h0F, 8'h01, 8'h00, 1'b0, 1);
        run_pixel(32'h1000, 26'h000061, 3'd1, 1'b1, 1'b1, 8'h0F, 8'h01, 8'h00, 1'b0, 0);
        run_pixel(32'h1000, 26'h000062, 3'd1, 1'b1, 1'b1, 8'h0F, 8'h01, 8'h00, 1'b1, 1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL text_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL text_txn[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_stall != exp_stall || idle_err + drop_err + tmo_cnt + stab_err != 0) $display("FAIL text_proto: got stall %0d err %0d want stall %0d err 0", obs_stall, idle_err + drop_err + tmo_cnt + stab_err, exp_stall);
        else n_pass++;
    endtask

    task automatic test_cache();
        int reads;
        int writes;
        clear_obs();
        preload(26'h003000, 8'hA5);
        for (int b = 0; b < 8; b++) begin
            run_pixel(32'h3000, ADDR_W'(26'h000070 + b), 3'(b), 1'b1, 1'b1, 8'hF0, 8'h0A, 8'h00, 1'b0, 1);
        end
        reads  = 0;
        writes = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i][TXN_W-1]) writes++;
            else reads++;
        end
        n_checks++;
        if (reads != CACHE_READS || writes != 8) $display("FAIL cache_counts: got %0d reads %0d writes want %0d reads 8 writes", reads, writes, CACHE_READS);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL cache_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL cache_txn[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_stall != exp_stall || idle_err + drop_err + tmo_cnt + stab_err != 0) $display("FAIL cache_proto: got stall %0d err %0d want stall %0d err 0", obs_stall, idle_err + drop_err + tmo_cnt + stab_err, exp_stall);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        clear_obs();
        ack_delay    = 6;
        p3_src_addr  = 32'h2200;
        p3_dest_addr = 26'h000044;
        p3_src_read  = 1'b1;
        p3_textmode  = 1'b0;
        trans_en     = 1'b0;
        p3_write_en  = 1'b1;
        @(negedge clock);
        p3_write_en = 1'b0;
        cyc = 0;
        while (mem_req !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        n_checks++;
        if (mem_req !== 1'b1 || mem_write !== 1'b0) $display("FAIL rst_read_start: got req %b write %b want req 1 write 0", mem_req, mem_write);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rst_async: got req %b stall %b want 0 0", mem_req, stall);
        else n_pass++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        m_valid = 1'b0;
        #1;
        n_checks++;
        if (idle !== 1'b1 || mem_write !== 1'b0) $display("FAIL rst_idle: got idle %b write %b want 1 0", idle, mem_write);
        else n_pass++;
        repeat (12) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 0 || mem_req !== 1'b0) $display("FAIL rst_no_write: got %0d txns req %b want 0 0", obs_q.size(), mem_req);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0]       src;
        logic [ADDR_W-1:0] dest;
        logic [7:0]        tc;
        clear_obs();
        for (int k = 0; k < 120; k++) begin
            src  = {6'($urandom), ADDR_W'(26'h003000 + $urandom_range(0, 3))};
            dest = ADDR_W'(26'h003000 + $urandom_range(0, 5));
            tc   = ($urandom_range(0, 1) == 1) ? ref_rd(src[ADDR_W-1:0]) : 8'($urandom);
            run_pixel(src, dest, 3'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                      8'($urandom), 8'($urandom), tc, 1'($urandom), int'($urandom_range(0, 3)));
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rand_txn[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_stall != exp_stall) $display("FAIL rand_stall: got %0d want %0d", obs_stall, exp_stall);
        else n_pass++;
        n_checks++;
        if (idle_err + drop_err + tmo_cnt + stab_err != 0) $display("FAIL rand_proto: got %0d/%0d/%0d/%0d want 0", idle_err, drop_err, tmo_cnt, stab_err);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        test_reset();
        @(negedge clock);
        test_fill();
        test_copy();
        test_transparency();
        test_text();
        test_cache();
        @(negedge clock);
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
